tmds_rx_decoder: RTL

- Receive-side counterpart of the DVI transmitter: one TMDS channel decoder.
- Takes the unaligned 10-bit parallel words from a 1:10 deserializer, one word per pixel clock.
- Finds the symbol boundary by hunting for control tokens, and selects the boundary with a 0..9 window offset (software bitslip).
- Decodes each aligned symbol into 8-bit data, or into a 2-bit control value plus DE, for downstream video capture.

---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_symbol_decode.sv | 40 ++++
 rtl/tmds_rx_decoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: symbol/data widths, the four control
// tokens and the alignment FSM state type.
package tmds_pkg;

  localparam int unsigned SYM_W       = 10;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned OFF_W       = 4;
  localparam int unsigned NUM_OFFSETS = 10;

  // Control tokens, written sym[9:0]; bit 0 is the first bit on the wire.
  localparam logic [SYM_W-1:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol.
//   sym      : aligned symbol, bit 0 earliest
//   is_token : symbol is one of the four control tokens
//   ctl      : {C1,C0} for a token, 0 otherwise
//   data     : decoded byte (meaningful only when is_token = 0)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0]  sym,
  output logic              is_token,
  output logic [1:0]        ctl,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] q;

  // Token lookup
  always_comb begin
    is_token = 1'b0;
    ctl      = 2'b00;
    case (sym)
      TOKEN_C00: begin is_token = 1'b1; ctl = 2'b00; end
      TOKEN_C01: begin is_token = 1'b1; ctl = 2'b01; end
      TOKEN_C10: begin is_token = 1'b1; ctl = 2'b10; end
      TOKEN_C11: begin is_token = 1'b1; ctl = 2'b11; end
      default:   begin is_token = 1'b0; ctl = 2'b00; end
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8)
  always_comb begin
    q    = sym[9] ? ~sym[DATA_W-1:0] : sym[DATA_W-1:0];
    data = '0;
    data[0] = q[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// One TMDS receive channel: word alignment by control-token hunting with a
// 0..9 bit window offset, followed by symbol decode to data or control.
//   clk, reset : pixel clock, synchronous active-high reset
//   raw_in     : unaligned deserialized word, bit 0 earliest
//   data_out   : decoded pixel byte (0 when not locked or on a token)
//   ctl_out    : decoded {C1,C0}; holds its last value across data symbols
//   de_out     : 1 = data symbol, 0 = control token
//   locked     : alignment achieved
//   offset     : current window offset 0..9
//   lock_lost  : one-cycle pulse when lock is dropped
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1024,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SYM_W-1:0]  raw_in,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        ctl_out,
  output logic              de_out,
  output logic              locked,
  output logic [OFF_W-1:0]  offset,
  output logic              lock_lost
);

  localparam int unsigned TMO_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned TMO_W   = $clog2(TMO_MAX);
  localparam int unsigned RUN_W   = $clog2(LOCK_COUNT + 1);

  localparam logic [TMO_W-1:0] SEARCH_LIMIT = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] LOSS_LIMIT   = TMO_W'(LOSS_TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(LOCK_COUNT - 1);
  localparam logic [OFF_W-1:0] LAST_OFFSET  = OFF_W'(NUM_OFFSETS - 1);

  rx_state_e           state;
  logic [SYM_W-1:0]    prev;
  logic [SYM_W-1:0]    sym_r;
  logic [RUN_W-1:0]    run;
  logic [TMO_W-1:0]    tmo;
  logic                refill;

  logic [2*SYM_W-1:0]  combined;
  logic                dec_is_token;
  logic [1:0]          dec_ctl;
  logic [DATA_W-1:0]   dec_data;

  // Two consecutive words; offset 0 picks the older word unchanged
  assign combined = {raw_in, prev};

  tmds_symbol_decode u_decode (
    .sym      (sym_r),
    .is_token (dec_is_token),
    .ctl      (dec_ctl),
    .data     (dec_data)
  );

  // Window, output register and alignment FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      prev      <= '0;
      sym_r     <= '0;
      run       <= '0;
      tmo       <= '0;
      refill    <= 1'b0;
      offset    <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      data_out  <= '0;
      ctl_out   <= '0;
      de_out    <= 1'b0;
    end else begin
      prev      <= raw_in;
      sym_r     <= SYM_W'(combined >> offset);
      lock_lost <= 1'b0;

      // Outputs follow the symbol only while locked
      if (state == LOCKED) begin
        if (dec_is_token) begin
          de_out   <= 1'b0;
          ctl_out  <= dec_ctl;
          data_out <= '0;
        end else begin
          de_out   <= 1'b1;
          data_out <= dec_data;
        end
      end else begin
        de_out   <= 1'b0;
        ctl_out  <= '0;
        data_out <= '0;
      end

      case (state)
        SEARCH: begin
          // sym_r was still framed with the old offset: skip it
          if (refill) begin
            refill <= 1'b0;
          end else if (dec_is_token) begin
            tmo <= '0;
            if (run >= RUN_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
              run    <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end else begin
            run <= '0;
            if (tmo >= SEARCH_LIMIT) begin
              offset <= (offset >= LAST_OFFSET) ? '0 : offset + OFF_W'(1);
              tmo    <= '0;
              refill <= 1'b1;
            end else begin
              tmo <= tmo + TMO_W'(1);
            end
          end
        end
        LOCKED: begin
          if (dec_is_token) begin
            tmo <= '0;
          end else if (tmo >= LOSS_LIMIT) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            lock_lost <= 1'b1;
            run       <= '0;
            tmo       <= '0;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
